// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer
// Dwell timer that sits upstream of the traffic-light FSM. It follows the FSM
// phase, counts the dwell for that phase and pulses 'advance' when the phase
// expires. It also latches pedestrian requests, which shorten GREEN, and it
// drives WALK during a RED phase that serves a request.
// Optional build macro: TPT_PRESCALE_EN. When it is defined, a tick occurs
// every PRESCALE clocks. When it is undefined, every clock is a tick.
module traffic_phase_timer #(
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned GREEN_TICKS   = 20,
  parameter int unsigned YELLOW_TICKS  = 4,
  parameter int unsigned RED_TICKS     = 16,
  parameter int unsigned PED_MIN_GREEN = 5,
  parameter int unsigned PRESCALE      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       state,
  input  logic             hold,
  input  logic             ped_req,
  output logic             advance,
  output logic [CNT_W-1:0] remaining,
  output logic             ped_walk,
  output logic             ped_ack
);

  localparam logic [1:0] PH_GREEN = 2'd0;
  localparam logic [1:0] PH_YELLOW = 2'd1;

  localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] RED_LOAD    = CNT_W'(RED_TICKS - 1);
  localparam logic [CNT_W-1:0] PED_LOAD    = CNT_W'(PED_MIN_GREEN - 1);

  typedef enum logic [1:0] {
    CTL_IDLE  = 2'd0,
    CTL_COUNT = 2'd1,
    CTL_WAIT  = 2'd2
  } ctl_t;

  ctl_t             ctl_q, ctl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       state_q, state_d;
  logic             advance_q, advance_d;
  logic             ped_pending_q, ped_pending_d;
  logic             ped_walk_q, ped_walk_d;
  logic             ped_ack_q, ped_ack_d;

  logic             reload;     // load the counter from the live phase this clock
  logic             count_en;   // COUNT state, same phase, not held
  logic             tick;       // this clock is a dwell tick
  logic             ped_now;    // a request is pending or is arriving this clock

  // The load value is the phase dwell minus one. Illegal phase 3 uses the RED dwell.
  function automatic logic [CNT_W-1:0] dur_load(input logic [1:0] s);
    case (s)
      PH_GREEN:  return GREEN_LOAD;
      PH_YELLOW: return YELLOW_LOAD;
      default:   return RED_LOAD;
    endcase
  endfunction

`ifdef TPT_PRESCALE_EN
  localparam int unsigned      PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LOAD = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_q, pre_d;

  assign tick = (pre_q == '0);

  // Prescaler. It reloads together with cnt and runs only while counting is enabled.
  always_comb begin
    pre_d = pre_q;
    if (reload) begin
      pre_d = PRE_LOAD;
    end else if (count_en) begin
      pre_d = tick ? PRE_LOAD : pre_q - 1'b1;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  assign ped_now = ped_pending_q | ped_req;

  // Control FSM next state. Reload takes priority over hold, and hold takes
  // priority over expiry.
  always_comb begin
    ctl_d         = ctl_q;
    cnt_d         = cnt_q;
    state_d       = state_q;
    advance_d     = 1'b0;
    ped_ack_d     = 1'b0;
    ped_walk_d    = ped_walk_q;
    ped_pending_d = ped_pending_q | ped_req;
    reload        = 1'b0;
    count_en      = 1'b0;

    case (ctl_q)
      CTL_IDLE: begin
        reload = 1'b1;
        ctl_d  = CTL_COUNT;
      end
      CTL_COUNT: begin
        if (state != state_q) begin
          reload = 1'b1;
        end else if (!hold) begin
          count_en = 1'b1;
          if (tick) begin
            if (cnt_q == '0) begin
              advance_d = 1'b1;
              ctl_d     = CTL_WAIT;
            end else if ((state_q == PH_GREEN) && ped_now && (cnt_q > PED_LOAD)) begin
              cnt_d = PED_LOAD;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
      end
      CTL_WAIT: begin
        if (state != state_q) begin
          reload = 1'b1;
          ctl_d  = CTL_COUNT;
        end
      end
      default: begin
        ctl_d = CTL_IDLE;
      end
    endcase

    if (reload) begin
      cnt_d   = dur_load(state);
      state_d = state;
      if (state[1]) begin
        // RED or illegal phase: serve a request that was latched earlier.
        if (ped_pending_q) begin
          ped_walk_d    = 1'b1;
          ped_ack_d     = 1'b1;
          ped_pending_d = ped_req;
        end
      end else begin
        ped_walk_d = 1'b0;
      end
    end
  end

  // State and output registers. The asynchronous reset clears every output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctl_q         <= CTL_IDLE;
      cnt_q         <= '0;
      state_q       <= 2'd0;
      advance_q     <= 1'b0;
      ped_pending_q <= 1'b0;
      ped_walk_q    <= 1'b0;
      ped_ack_q     <= 1'b0;
    end else begin
      ctl_q         <= ctl_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      advance_q     <= advance_d;
      ped_pending_q <= ped_pending_d;
      ped_walk_q    <= ped_walk_d;
      ped_ack_q     <= ped_ack_d;
    end
  end

  assign advance   = advance_q;
  assign remaining = cnt_q;
  assign ped_walk  = ped_walk_q;
  assign ped_ack   = ped_ack_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Testbench for traffic_phase_timer with the default parameters. It applies a
// table of per-cycle vectors and then runs hand-written sequences for the
// closed-loop phase stepping and for a reset in the middle of RED.
module tb_traffic_phase_timer;

  logic       clk;
  logic       rst;
  logic [1:0] state;
  logic       hold;
  logic       ped_req;
  logic       advance;
  logic [7:0] remaining;
  logic       ped_walk;
  logic       ped_ack;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] st;
    logic       h;
    logic       r;
    logic       adv;
    logic [7:0] rem;
    logic       walk;
    logic       ack;
  } vec_t;

  vec_t vecs[$];

  traffic_phase_timer dut (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .hold      (hold),
    .ped_req   (ped_req),
    .advance   (advance),
    .remaining (remaining),
    .ped_walk  (ped_walk),
    .ped_ack   (ped_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stop a run that hangs.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Wait for one rising edge, then move to the falling edge to sample and drive.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic [1:0] st, input logic h, input logic r, input logic adv,
                     input int rem, input logic walk, input logic ack);
    vec_t v;
    v.st = st; v.h = h; v.r = r; v.adv = adv; v.rem = 8'(rem); v.walk = walk; v.ack = ack;
    vecs.push_back(v);
  endtask

  // Count rising edges until advance is seen. The count is bounded.
  task automatic wait_adv(output int n);
    n = 0;
    while (!advance && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".advance"},   int'(advance),   0);
    check({tag, ".remaining"}, int'(remaining), 0);
    check({tag, ".ped_walk"},  int'(ped_walk),  0);
    check({tag, ".ped_ack"},   int'(ped_ack),   0);
  endtask

  initial begin
    int n;

    // Table of per-cycle vectors. Each row is {inputs, expected outputs after the edge}.
    add(0, 0, 0, 0, 19, 0, 0);                             // IDLE load edge
    for (int k = 18; k >= 15; k--) add(0, 0, 0, 0, k, 0, 0);
    add(0, 0, 1, 0, 4, 0, 0);                              // request at 15 gives 4
    for (int k = 3; k >= 0; k--) add(0, 0, 0, 0, k, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0);                              // 5 edges after shortening
    add(1, 0, 0, 0, 3, 0, 0);                              // YELLOW
    for (int k = 2; k >= 0; k--) add(1, 0, 0, 0, k, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0);
    add(2, 0, 0, 0, 15, 1, 1);                             // RED serves the request
    for (int k = 14; k >= 0; k--) add(2, 0, 0, 0, k, 1, 0);
    add(0, 0, 0, 0, 19, 0, 0);                             // phase change on cnt==0: reload, no pulse
    add(0, 0, 0, 0, 18, 0, 0);
    add(0, 0, 1, 0, 4, 0, 0);
    for (int k = 3; k >= 0; k--) add(0, 0, 0, 0, k, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 3, 0, 0);
    add(1, 0, 0, 0, 2, 0, 0);
    for (int k = 0; k < 7; k++) add(1, 1, 0, 0, 2, 0, 0);  // hold for 7 clocks mid-YELLOW
    add(1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0);                              // pulse is 7 clocks late
    add(2, 0, 0, 0, 15, 1, 1);
    for (int k = 14; k >= 0; k--) add(2, 0, 0, 0, k, 1, 0);
    for (int k = 0; k < 3; k++) add(2, 1, 0, 0, 0, 1, 0);  // expiry under hold: no pulse
    add(2, 0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 19, 0, 0);                             // GREEN clears WALK

    // Reset state.
    rst = 1'b0; state = 2'd0; hold = 1'b0; ped_req = 1'b0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b1;

    foreach (vecs[i]) begin
      state   = vecs[i].st;
      hold    = vecs[i].h;
      ped_req = vecs[i].r;
      step();
      $display("vec %0d: st=%0d hold=%0d req=%0d -> adv=%0d rem=%0d walk=%0d ack=%0d",
               i, vecs[i].st, vecs[i].h, vecs[i].r, advance, remaining, ped_walk, ped_ack);
      check($sformatf("vec%0d.advance", i),   int'(advance),   int'(vecs[i].adv));
      check($sformatf("vec%0d.remaining", i), int'(remaining), int'(vecs[i].rem));
      check($sformatf("vec%0d.ped_walk", i),  int'(ped_walk),  int'(vecs[i].walk));
      check($sformatf("vec%0d.ped_ack", i),   int'(ped_ack),   int'(vecs[i].ack));
    end
    state = 2'd0; hold = 1'b0; ped_req = 1'b0;

    // Closed loop: the bench steps 0->1->2->0 on each advance. Load-to-pulse is DUR.
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();                                                // load edge for GREEN
    wait_adv(n);
    $display("loop GREEN: advance after %0d clocks", n);
    check("loop.green_dur", n, 20);
    state = 2'd1;
    step();
    check("loop.yellow_load", int'(remaining), 3);
    wait_adv(n);
    $display("loop YELLOW: advance after %0d clocks", n);
    check("loop.yellow_dur", n, 4);
    state = 2'd2;
    step();
    check("loop.red_load", int'(remaining), 15);
    wait_adv(n);
    $display("loop RED: advance after %0d clocks", n);
    check("loop.red_dur", n, 16);
    state = 2'd0;
    step();
    check("loop.green_reload", int'(remaining), 19);

    // Reset in the middle of RED with WALK lit.
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    check("mid.shorten", int'(remaining), 4);
    wait_adv(n);
    check("mid.shorten_dur", n, 5);
    state = 2'd1;
    step();
    wait_adv(n);
    check("mid.yellow_dur", n, 4);
    state = 2'd2;
    step();
    $display("mid RED entry: walk=%0d ack=%0d rem=%0d", ped_walk, ped_ack, remaining);
    check("mid.walk", int'(ped_walk), 1);
    check("mid.ack", int'(ped_ack), 1);
    step();
    check("mid.ack_single", int'(ped_ack), 0);
    step();
    check("mid.rem", int'(remaining), 13);
    #2 rst = 1'b0;
    #1;
    $display("async reset mid-RED: adv=%0d rem=%0d walk=%0d ack=%0d",
             advance, remaining, ped_walk, ped_ack);
    check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b1;
    step();
    $display("after reset release: rem=%0d walk=%0d", remaining, ped_walk);
    check("post_rst.reload", int'(remaining), 15);
    check("post_rst.walk", int'(ped_walk), 0);
    check("post_rst.advance", int'(advance), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
